// File: rtl/perm_pkg.sv
// -----------------------------------------------------------------------------
// perm_pkg
// Shared types for the bit-permute datapath and the lanes that feed it.
//   perm_mode_e  : 2-bit permute mode selector
//   PERM_MODE_W  : width of one mode field on a packed request bus
// -----------------------------------------------------------------------------
package perm_pkg;

  localparam int PERM_MODE_W = 2;

  typedef enum logic [PERM_MODE_W-1:0] {
    PERM_REV   = 2'd0,  // bit reverse
    PERM_PASS  = 2'd1,  // identity
    PERM_SWAP  = 2'd2,  // swap each adjacent bit pair
    PERM_ROTL2 = 2'd3   // rotate left by two
  } perm_mode_e;

endpackage

// File: rtl/permute_arb_if.sv
// -----------------------------------------------------------------------------
// permute_arb_if
// Bundles the NREQ-way request side and the single result side of the
// shared permute arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_data            : requester i word at [i*WIDTH +: WIDTH]
//   req_mode            : requester i mode at [i*PERM_MODE_W +: PERM_MODE_W]
//   out_valid/out_ready : result handshake
//   out_data/out_src    : permuted word and index of its requester
// Modports:
//   master : producers + consumer (drive requests, accept results)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface permute_arb_if
  import perm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 4,
  parameter int NREQ_W = 2
);

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ*WIDTH-1:0]       req_data;
  logic [NREQ*PERM_MODE_W-1:0] req_mode;

  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [NREQ_W-1:0]           out_src;

  modport master (
    output req_valid, req_data, req_mode, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data, req_mode, out_ready,
    output req_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/perm_bits.sv
// -----------------------------------------------------------------------------
// perm_bits
// Purely combinational WIDTH-bit permute network, reusable by any lane.
//   in   : input word
//   mode : PERM_REV / PERM_PASS / PERM_SWAP / PERM_ROTL2
//   out  : permuted word
// WIDTH must be even (pair swap) and >= 4.
// -----------------------------------------------------------------------------
module perm_bits
  import perm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  perm_mode_e       mode,
  output logic [WIDTH-1:0] out
);

  // Each output bit is a 4:1 mux over the four source bits it could come
  // from; the source positions are elaboration-time constants per bit, so
  // the network reduces to WIDTH small muxes with no shifters.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int REV_SRC  = WIDTH - 1 - i;
    localparam int SWAP_SRC = i ^ 1;
    // rotate left by 2: result bit i takes input bit i-2, wrapping
    localparam int ROTL_SRC = (i + WIDTH - 2) % WIDTH;

    logic [3:0] cand;

    assign cand   = {in[ROTL_SRC], in[SWAP_SRC], in[i], in[REV_SRC]};
    assign out[i] = cand[mode];
  end

endmodule

// File: rtl/permute_arb.sv
// -----------------------------------------------------------------------------
// permute_arb
// Round-robin arbiter that shares one perm_bits datapath among NREQ
// requesters through a two-stage pipeline:
//   stage 1 : registered winning request (data, mode, source index)
//   stage 2 : registered permuted result presented on out_*
// Ports:
//   clk     : clock, all state on posedge
//   reset_l : asynchronous active-low reset
//   bus     : permute_arb_if.slave (request and result handshakes)
// Accept-to-out_valid latency is 2 cycles; throughput is 1/cycle while the
// consumer keeps out_ready high. The only stall is both stages full with
// out_ready low, in which case no requester is granted.
// -----------------------------------------------------------------------------
module permute_arb
  import perm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 4,
  parameter int NREQ_W = 2
) (
  input logic          clk,
  input logic          reset_l,
  permute_arb_if.slave bus
);

  // Stage 1 registers
  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;
  perm_mode_e        s1_mode;
  logic [NREQ_W-1:0] s1_idx;

  // Stage 2 registers (drive the result side directly)
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [NREQ_W-1:0] out_src;

  // Round-robin pointer: index of the most recent winner
  logic [NREQ_W-1:0] last;

  // Pipeline advance and grant
  logic              s2_adv;
  logic              s1_adv;
  logic              can_take;
  logic [NREQ-1:0]   grant;
  logic [NREQ_W-1:0] grant_idx;
  logic              grant_found;
  int                probe;

  logic [WIDTH-1:0]  sel_data;
  perm_mode_e        sel_mode;
  logic [WIDTH-1:0]  perm_out;

  // Stage 2 can take a new word when it is empty or being drained this
  // cycle; stage 1 can take one when it is empty or moving into stage 2.
  always_comb begin
    s2_adv   = !out_valid || bus.out_ready;
    s1_adv   = s1_valid && s2_adv;
    can_take = !s1_valid || s1_adv;
  end

  // Round-robin search starting just after the last winner. probe walks
  // last+1 .. last+NREQ with an explicit wrap so NREQ need not be a power
  // of two.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    probe       = 0;
    if (can_take) begin
      for (int k = 1; k <= NREQ; k++) begin
        probe = int'(last) + k;
        if (probe >= NREQ) begin
          probe = probe - NREQ;
        end
        if (!grant_found && bus.req_valid[probe]) begin
          grant_found      = 1'b1;
          grant_idx        = NREQ_W'(probe);
          grant[probe]     = 1'b1;
        end
      end
    end
  end

  // Ready is forced low during reset: the stage registers are cleared then,
  // which would otherwise make can_take true and expose a grant.
  assign bus.req_ready = reset_l ? grant : '0;

  // Winner's word and mode, selected by index
  always_comb begin
    sel_data = bus.req_data[grant_idx*WIDTH +: WIDTH];
    sel_mode = perm_mode_e'(bus.req_mode[grant_idx*PERM_MODE_W +: PERM_MODE_W]);
  end

  perm_bits #(
    .WIDTH (WIDTH)
  ) u_perm (
    .in   (s1_data),
    .mode (s1_mode),
    .out  (perm_out)
  );

  // Stage 1: capture on a grant; empty out when the word moves on and
  // nothing replaces it. The RR pointer only moves on an actual grant.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= PERM_REV;
      s1_idx   <= '0;
      last     <= NREQ_W'(NREQ - 1);
    end else begin
      if (grant_found) begin
        s1_valid <= 1'b1;
        s1_data  <= sel_data;
        s1_mode  <= sel_mode;
        s1_idx   <= grant_idx;
        last     <= grant_idx;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: load the permuted word on s1_adv. When drained without a
  // replacement only the valid bit drops; data and src keep their values.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        out_data  <= perm_out;
        out_src   <= s1_idx;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_src   = out_src;

`ifndef SYNTHESIS
  // At most one requester accepted per cycle
  a_ready_onehot: assert property (
    @(posedge clk) disable iff (!reset_l) $onehot0(bus.req_ready)
  );

  // A stalled result must be held unchanged until taken
  a_stall_hold: assert property (
    @(posedge clk) disable iff (!reset_l)
    (out_valid && !bus.out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src))
  );
`endif

endmodule
